// File: rtl/dmem_responder.sv
// Valid/ready data-memory responder: accepts one word-addressed load/store at a time,
// waits LATENCY cycles, then presents read data or a write acknowledge until taken.
module dmem_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);
    localparam int         AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        we_q;
    logic [31:0] addr_q, wdata_q;
    logic [3:0]  be_q;

    logic [31:0] mem_q [DEPTH];

    logic          commit;
    logic          c_we, c_err;
    logic [31:0]   c_addr, c_wdata;
    logic [3:0]    c_be;
    logic [AW-1:0] c_idx;

    // With LATENCY=0 the commit edge is the accepting edge, so the live request is used.
    always_comb begin
        if (state_q == IDLE) begin
            c_we    = req_we;
            c_addr  = req_addr;
            c_wdata = req_wdata;
            c_be    = req_be;
        end else begin
            c_we    = we_q;
            c_addr  = addr_q;
            c_wdata = wdata_q;
            c_be    = be_q;
        end
        c_err = (c_addr[1:0] != 2'b00) || ({2'b00, c_addr[31:2]} >= 32'(DEPTH));
        c_idx = c_addr[AW+1:2];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        commit  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (LATENCY > 0) begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end else begin
                        state_d = RESP;
                        commit  = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                    rdata_d = 32'd0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        if (commit) begin
            err_d   = c_err;
            rdata_d = (c_we || c_err) ? 32'd0 : mem_q[c_idx];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == IDLE && req_valid) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            be_q    <= req_be;
        end
    end

    // Array survives reset; only a commit edge outside reset may write it.
    always_ff @(posedge clk) begin
        if (commit && !reset && c_we && !c_err) begin
            for (int b = 0; b < 4; b++) begin
                if (c_be[b]) begin
                    mem_q[c_idx][8*b +: 8] <= c_wdata[8*b +: 8];
                end
            end
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a LATENCY=2 and a LATENCY=0 instance driven from shared
// stimulus, compared against a byte-level reference memory per instance.
module tb_dmem_responder;
    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic [3:0]  req_be = 4'd0;
    logic        resp_ready = 1'b0;
    logic        sel = 1'b0;

    logic        rdy2, vld2, err2, rdy0, vld0, err0;
    logic [31:0] rd2, rd0;
    logic        rv2, rv0;
    logic        m_req_ready, m_resp_valid, m_err;
    logic [31:0] m_rdata;

    int n_cmp = 0;
    int n_mis = 0;

    logic [31:0] ref_mem [2][DEPTH];

    assign rv2 = req_valid & ~sel;
    assign rv0 = req_valid & sel;
    assign m_req_ready  = sel ? rdy0 : rdy2;
    assign m_resp_valid = sel ? vld0 : vld2;
    assign m_rdata      = sel ? rd0 : rd2;
    assign m_err        = sel ? err0 : err2;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(2)) u_l2 (
        .clk(clk), .reset(reset), .req_valid(rv2), .req_ready(rdy2), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .resp_valid(vld2),
        .resp_ready(resp_ready), .resp_rdata(rd2), .resp_err(err2)
    );

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(0)) u_l0 (
        .clk(clk), .reset(reset), .req_valid(rv0), .req_ready(rdy0), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .resp_valid(vld0),
        .resp_ready(resp_ready), .resp_rdata(rd0), .resp_err(err0)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: aligned word inside DEPTH is valid; stores merge enabled bytes, loads return the word.
    function automatic void ref_txn(input int d, input bit we, input logic [31:0] a,
                                    input logic [31:0] wd, input logic [3:0] be,
                                    output bit err, output logic [31:0] rd);
        int idx;
        err = (a % 4 != 0) || ((a / 4) >= DEPTH);
        rd  = 32'd0;
        if (!err) begin
            idx = int'(a / 4);
            if (we) begin
                for (int b = 0; b < 4; b++)
                    if (be[b]) ref_mem[d][idx][8*b +: 8] = wd[8*b +: 8];
            end else begin
                rd = ref_mem[d][idx];
            end
        end
    endfunction

    task automatic run(input int d, input bit we, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] be, input int hold);
        bit          e_err;
        logic [31:0] e_rd;
        int          n;
        ref_txn(d, we, a, wd, be, e_err, e_rd);
        sel = d[0]; req_we = we; req_addr = a; req_wdata = wd; req_be = be;
        resp_ready = 1'b0; req_valid = 1'b1;
        n = 0;
        while (!m_req_ready && n < 50) begin @(posedge clk); #1; n++; end
        chk("req_ready_before_accept", 32'(m_req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 0;
        while (!m_resp_valid && n < 50) begin @(posedge clk); #1; n++; end
        chk("latency", 32'(n), (d == 1) ? 32'd0 : 32'd2);
        chk("req_ready_in_resp", 32'(m_req_ready), 32'd0);
        chk("resp_rdata", m_rdata, e_rd);
        chk("resp_err", 32'(m_err), 32'(e_err));
        repeat (hold) begin
            @(posedge clk); #1;
            chk("hold_valid", 32'(m_resp_valid), 32'd1);
            chk("hold_rdata", m_rdata, e_rd);
            chk("hold_err", 32'(m_err), 32'(e_err));
            chk("hold_req_ready", 32'(m_req_ready), 32'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        chk("post_valid", 32'(m_resp_valid), 32'd0);
        chk("post_req_ready", 32'(m_req_ready), 32'd1);
        chk("post_rdata", m_rdata, 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        #3;
        for (int d = 0; d < 2; d++) begin
            sel = d[0]; #1;
            chk("rst_req_ready", 32'(m_req_ready), 32'd1);
            chk("rst_resp_valid", 32'(m_resp_valid), 32'd0);
            chk("rst_rdata", m_rdata, 32'd0);
            chk("rst_err", 32'(m_err), 32'd0);
        end
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;

        for (int i = 0; i < DEPTH; i++)
            for (int d = 0; d < 2; d++)
                run(d, 1'b1, 32'(i * 4), $urandom, 4'hF, 0);

        run(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0);
        run(0, 1'b0, 32'h10, 32'h0, 4'h0, 0);
        run(0, 1'b1, 32'h10, 32'h000000AA, 4'b0001, 0);
        run(0, 1'b0, 32'h10, 32'h0, 4'h0, 0);
        chk("partial_merge_model", ref_mem[0][4], 32'hDEADBEAA);
        run(0, 1'b0, 32'h12, 32'h0, 4'h0, 0);
        run(0, 1'b1, 32'h0, 32'hCAFEF00D, 4'hF, 0);
        run(0, 1'b1, 32'h400, 32'h11111111, 4'hF, 0);
        run(0, 1'b0, 32'h0, 32'h0, 4'h0, 0);
        run(0, 1'b0, 32'h3FC, 32'h0, 4'h0, 0);
        run(0, 1'b0, 32'h10, 32'h0, 4'h0, 5);
        run(0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, 0);
        run(0, 1'b0, 32'h10, 32'h0, 4'h0, 0);

        // Reset while a store is still waiting: it must never land.
        sel = 1'b0; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678; req_be = 4'hF;
        chk("rstwait_req_ready", 32'(m_req_ready), 32'd1);
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1; #1;
        chk("rstwait_req_ready_now", 32'(m_req_ready), 32'd1);
        chk("rstwait_resp_valid", 32'(m_resp_valid), 32'd0);
        chk("rstwait_rdata", m_rdata, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        run(0, 1'b0, 32'h20, 32'h0, 4'h0, 0);

        // Back-to-back loads on the zero-latency instance with resp_ready tied high.
        sel = 1'b1; resp_ready = 1'b1; req_we = 1'b0; req_addr = 32'h0; req_be = 4'h0;
        req_valid = 1'b1;
        @(posedge clk); #1;
        chk("b2b_vld0", 32'(m_resp_valid), 32'd1);
        chk("b2b_rd0", m_rdata, ref_mem[1][0]);
        chk("b2b_rdy0", 32'(m_req_ready), 32'd0);
        req_addr = 32'h4;
        @(posedge clk); #1;
        chk("b2b_gap_vld", 32'(m_resp_valid), 32'd0);
        chk("b2b_gap_rdy", 32'(m_req_ready), 32'd1);
        @(posedge clk); #1;
        chk("b2b_vld1", 32'(m_resp_valid), 32'd1);
        chk("b2b_rd1", m_rdata, ref_mem[1][1]);
        req_valid = 1'b0;
        @(posedge clk); #1;
        chk("b2b_end_vld", 32'(m_resp_valid), 32'd0);
        resp_ready = 1'b0;

        repeat (200) begin
            int k;
            k = int'($urandom_range(0, 9));
            a = 32'($urandom_range(0, DEPTH - 1)) * 32'd4;
            if (k == 0) a = a + 32'($urandom_range(1, 3));
            else if (k == 1) a = $urandom | 32'h0000_0400;
            else if (k == 2) a = 32'(DEPTH * 4 - 4);
            run(int'($urandom_range(0, 1)), 1'($urandom), a, $urandom, 4'($urandom),
                int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
